// File: rtl/ram_block_copier_if.sv
// Control handshake and dual-port RAM pins of the block copier, bundled.
// master: the copier itself (drives the RAM pins, reports busy/done).
// slave:  the surrounding control logic and RAM.
interface ram_block_copier_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
);
   logic              start;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [ADDR_W:0]   len;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] ram_addr_a;
   logic              ram_we_a;
   logic [DATA_W-1:0] ram_data_a;
   logic [DATA_W-1:0] ram_q_a;
   logic [ADDR_W-1:0] ram_addr_b;
   logic              ram_we_b;
   logic [DATA_W-1:0] ram_data_b;

   modport master (
      input  start, src_addr, dst_addr, len, ram_q_a,
      output busy, done, ram_addr_a, ram_we_a, ram_data_a,
             ram_addr_b, ram_we_b, ram_data_b
   );

   modport slave (
      output start, src_addr, dst_addr, len, ram_q_a,
      input  busy, done, ram_addr_a, ram_we_a, ram_data_a,
             ram_addr_b, ram_we_b, ram_data_b
   );
endinterface

// File: rtl/ram_block_copier.sv
// Block copy engine for a dual-port RAM: reads through port A, writes through
// port B one cycle later, one word per clock, hiding the 1-cycle read latency.
module ram_block_copier #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   ram_block_copier_if.master bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [ADDR_W:0]   DEPTH = (ADDR_W + 1)'(1) << ADDR_W;
   localparam logic [ADDR_W:0]   ONE_L = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

   state_t            state_q;
   logic [ADDR_W-1:0] src_q, dst_q;
   logic [ADDR_W-1:0] addr_a_q, addr_b_q;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   rd_cnt_q;
   logic [ADDR_W-1:0] wr_cnt_q;
   logic              busy_q, done_q, we_b_q;
   logic [ADDR_W:0]   len_d;

   // Saturate the requested length to the RAM depth.
   always_comb begin
      len_d = bus.len;
      if (bus.len > DEPTH) len_d = DEPTH;
   end

   // Copy FSM; rd_cnt_q counts reads already issued, and the write stage
   // trails the read stage by exactly one cycle while in RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         we_b_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               we_b_q <= 1'b0;
               if (bus.start) begin
                  if (len_d == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     src_q    <= bus.src_addr;
                     dst_q    <= bus.dst_addr;
                     len_q    <= len_d;
                     addr_a_q <= bus.src_addr;
                     rd_cnt_q <= ONE_L;
                     wr_cnt_q <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= RUN;
                  end
               end
            end
            RUN: begin
               we_b_q   <= 1'b1;
               addr_b_q <= dst_q + wr_cnt_q;
               wr_cnt_q <= wr_cnt_q + ONE_A;
               if (rd_cnt_q == len_q) begin
                  state_q <= DRAIN;
               end else begin
                  addr_a_q <= src_q + rd_cnt_q[ADDR_W-1:0];
                  rd_cnt_q <= rd_cnt_q + ONE_L;
               end
            end
            DRAIN: begin
               we_b_q  <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.ram_addr_a = addr_a_q;
   assign bus.ram_we_a   = 1'b0;
   assign bus.ram_data_a = '0;
   assign bus.ram_addr_b = addr_b_q;
   assign bus.ram_we_b   = we_b_q;
   assign bus.ram_data_b = bus.ram_q_a;

endmodule
